// File: rtl/systolic_pkg.sv
// Shared definitions for the 4x4 systolic array and its skew feeder.
package systolic_pkg;

   localparam int ARRAY_DIM  = 4;
   localparam int FEED_STEPS = 2 * ARRAY_DIM - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Bit offset of element (row, col) in a row-major packed tile.
   function automatic int unsigned elem_off(input int unsigned row, input int unsigned col,
                                            input int unsigned width);
      return (row * ARRAY_DIM + col) * width;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One skewed lane: registers vec[step-LANE] while enabled, otherwise zero.
module skew_lane
   import systolic_pkg::*;
#(
   parameter int LANE      = 0,
   parameter int BIT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic [2:0]                     step,
   input  logic [ARRAY_DIM*BIT_WIDTH-1:0] vec,
   output logic [BIT_WIDTH-1:0]           lane_out
);

   logic [BIT_WIDTH-1:0] out_d;
   logic [BIT_WIDTH-1:0] out_q;
   logic [2:0]           pos;

   always_comb begin
      pos   = step - 3'(LANE);
      out_d = '0;
      if (en && (step >= 3'(LANE)) && (pos < 3'(ARRAY_DIM))) begin
         out_d = vec[int'(pos[1:0]) * BIT_WIDTH +: BIT_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign lane_out = out_q;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for systolic_array_4x4.
// Define SKEW_FEEDER_B_COLMAJOR_EN to take b_tile in column-major layout.
//
// state | meaning
// IDLE  | ready for a tile pair; block_done pulses here on the first cycle
// FEED  | driving skew steps 0..6 onto west/north
// DRAIN | outputs zero while the array finishes, DRAIN_CYC cycles
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int BIT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int DRAIN_CYC  = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [16*BIT_WIDTH-1:0] a_tile,
   input  logic [16*BIT_WIDTH-1:0] b_tile,
   output logic [BIT_WIDTH-1:0]    west_in0,
   output logic [BIT_WIDTH-1:0]    west_in1,
   output logic [BIT_WIDTH-1:0]    west_in2,
   output logic [BIT_WIDTH-1:0]    west_in3,
   output logic [BIT_WIDTH-1:0]    north_in0,
   output logic [BIT_WIDTH-1:0]    north_in1,
   output logic [BIT_WIDTH-1:0]    north_in2,
   output logic [BIT_WIDTH-1:0]    north_in3,
   output logic                    busy,
   output logic                    block_done
);

   localparam int TILE_W = ARRAY_DIM * ARRAY_DIM * BIT_WIDTH;
   localparam int VEC_W  = ARRAY_DIM * BIT_WIDTH;
   localparam int DRN_W  = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
   localparam logic [2:0]       LAST_STEP  = 3'(FEED_STEPS - 1);

   if (FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_frac
      $error("FRAC_WIDTH must be smaller than BIT_WIDTH");
   end

   state_e             state_q, state_d;
   logic [2:0]         step_q, step_d;
   logic [DRN_W-1:0]   drain_q, drain_d;
   logic [TILE_W-1:0]  a_q, a_d, b_q, b_d;
   logic               done_q, done_d;
   logic               accept;
   logic               lane_en;
   logic [2:0]         lane_step;
   logic [TILE_W-1:0]  a_src, b_src;

   logic [ARRAY_DIM-1:0][VEC_W-1:0] west_vec;
   logic [ARRAY_DIM-1:0][VEC_W-1:0] north_vec;
   logic [BIT_WIDTH-1:0]            west_lane  [ARRAY_DIM];
   logic [BIT_WIDTH-1:0]            north_lane [ARRAY_DIM];

   assign accept   = (state_q == IDLE) && in_valid;
   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      drain_d   = drain_q;
      a_d       = a_q;
      b_d       = b_q;
      done_d    = 1'b0;
      lane_en   = 1'b0;
      lane_step = step_q + 3'd1;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = FEED;
               step_d    = '0;
               a_d       = a_tile;
               b_d       = b_tile;
               lane_en   = 1'b1;
               lane_step = '0;
            end
         end
         FEED: begin
            if (step_q == LAST_STEP) begin
               step_d  = '0;
               drain_d = '0;
               if (DRAIN_CYC == 0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               step_d  = step_q + 3'd1;
               lane_en = 1'b1;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = IDLE;
               drain_d = '0;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         drain_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         drain_q <= drain_d;
         a_q     <= a_d;
         b_q     <= b_d;
         done_q  <= done_d;
      end
   end

   // Step 0 is loaded on the accept edge, before the tile registers hold the new pair.
   assign a_src = accept ? a_tile : a_q;
   assign b_src = accept ? b_tile : b_q;

   for (genvar gl = 0; gl < ARRAY_DIM; gl++) begin : g_lane
      for (genvar gk = 0; gk < ARRAY_DIM; gk++) begin : g_elem
         assign west_vec[gl][gk*BIT_WIDTH +: BIT_WIDTH] = a_src[elem_off(gl, gk, BIT_WIDTH) +: BIT_WIDTH];
`ifdef SKEW_FEEDER_B_COLMAJOR_EN
         assign north_vec[gl][gk*BIT_WIDTH +: BIT_WIDTH] = b_src[elem_off(gl, gk, BIT_WIDTH) +: BIT_WIDTH];
`else
         assign north_vec[gl][gk*BIT_WIDTH +: BIT_WIDTH] = b_src[elem_off(gk, gl, BIT_WIDTH) +: BIT_WIDTH];
`endif
      end

      skew_lane #(.LANE(gl), .BIT_WIDTH(BIT_WIDTH)) u_west (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (lane_en),
         .step     (lane_step),
         .vec      (west_vec[gl]),
         .lane_out (west_lane[gl])
      );

      skew_lane #(.LANE(gl), .BIT_WIDTH(BIT_WIDTH)) u_north (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (lane_en),
         .step     (lane_step),
         .vec      (north_vec[gl]),
         .lane_out (north_lane[gl])
      );
   end

   assign west_in0   = west_lane[0];
   assign west_in1   = west_lane[1];
   assign west_in2   = west_lane[2];
   assign west_in3   = west_lane[3];
   assign north_in0  = north_lane[0];
   assign north_in1  = north_lane[1];
   assign north_in2  = north_lane[2];
   assign north_in3  = north_lane[3];
   assign block_done = done_q;

endmodule
